// File: rtl/mitchell_pkg.sv
// Width helpers and per-stage control records for the Mitchell log-domain multiplier.
// Build option: define MITCHELL_SIGNED_EN for two's-complement operands (adds a sign bit per stage).
package mitchell_pkg;

  function automatic int unsigned max_bw(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // At least one bit so a 1-bit operand still gets a legal k field.
  function automatic int unsigned k_bw(input int unsigned w);
    return (w <= 32'd1) ? 32'd1 : $clog2(w);
  endfunction

  typedef struct packed {
    logic valid;
    logic zero;
`ifdef MITCHELL_SIGNED_EN
    logic neg;
`endif
  } s1_ctl_t;

  typedef struct packed {
    logic valid;
    logic zero;
`ifdef MITCHELL_SIGNED_EN
    logic neg;
`endif
  } s2_ctl_t;

endpackage

// File: rtl/mitchell_lod.sv
// Leading-one detector: index k of the highest set bit, the bits below it
// left-aligned into a W-bit fraction, and a flag for an all-zero input.
module mitchell_lod
  import mitchell_pkg::*;
#(
  parameter int unsigned W  = 16,
  parameter int unsigned KW = 4
) (
  input  logic [W-1:0]  val,
  output logic [KW-1:0] k,
  output logic [W-1:0]  frac,
  output logic          zero
);

  // Upward scan: the last set bit seen is the leading one, so it wins.
  always_comb begin
    k    = {KW{1'b0}};
    frac = {W{1'b0}};
    for (int unsigned i = 0; i < W; i++) begin
      k    = val[i] ? KW'(i) : k;
      frac = val[i] ? (val << (W - i)) : frac;
    end
    zero = (val == {W{1'b0}});
  end

endmodule

// File: rtl/mitchell_mult_pipe.sv
// Three-stage Mitchell approximate multiplier with valid/ready handshake and sideband tag.
// Build option: MITCHELL_SIGNED_EN selects two's-complement operands and result.
module mitchell_mult_pipe
  import mitchell_pkg::*;
#(
  parameter int unsigned A_BW   = 16,
  parameter int unsigned B_BW   = 16,
  parameter int unsigned TAG_BW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_BW-1:0]      in_a,
  input  logic [B_BW-1:0]      in_b,
  input  logic [TAG_BW-1:0]    in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [A_BW+B_BW-1:0] out_c,
  output logic [TAG_BW-1:0]    out_tag
);

  localparam int unsigned MAX_BW = max_bw(A_BW, B_BW);
  localparam int unsigned K_BW   = k_bw(MAX_BW);
  localparam int unsigned C_BW   = A_BW + B_BW;
  localparam int unsigned E_BW   = K_BW + 1;
  localparam logic [E_BW-1:0] FRAC_SH = E_BW'(MAX_BW);

  logic              en;
  logic [A_BW-1:0]   mag_a;
  logic [B_BW-1:0]   mag_b;
  logic [MAX_BW-1:0] lod_a_in, lod_b_in, x_a, x_b;
  logic [K_BW-1:0]   k_a, k_b;
  logic              zero_a, zero_b;

  s1_ctl_t           s1_ctl_d, s1_ctl_q;
  logic [K_BW-1:0]   s1_ka_d, s1_ka_q, s1_kb_d, s1_kb_q;
  logic [MAX_BW-1:0] s1_xa_d, s1_xa_q, s1_xb_d, s1_xb_q;
  logic [TAG_BW-1:0] s1_tag_d, s1_tag_q;

  s2_ctl_t           s2_ctl_d, s2_ctl_q;
  logic [E_BW-1:0]   s2_ksum_d, s2_ksum_q;
  logic [MAX_BW:0]   s2_fsum_d, s2_fsum_q;
  logic [TAG_BW-1:0] s2_tag_d, s2_tag_q;

  logic              out_valid_d, out_valid_q;
  logic [C_BW-1:0]   out_c_d, out_c_q;
  logic [TAG_BW-1:0] out_tag_d, out_tag_q;

  logic [E_BW-1:0]   s3_exp;
  logic [C_BW-1:0]   s3_mant, s3_mag, s3_res;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

`ifdef MITCHELL_SIGNED_EN
  logic neg_in;

  // Magnitudes; the most negative code negates to itself, which reads as 2^(BW-1) unsigned.
  always_comb begin
    mag_a  = in_a[A_BW-1] ? (A_BW'(0) - in_a) : in_a;
    mag_b  = in_b[B_BW-1] ? (B_BW'(0) - in_b) : in_b;
    neg_in = in_a[A_BW-1] ^ in_b[B_BW-1];
  end
`else
  always_comb begin
    mag_a = in_a;
    mag_b = in_b;
  end
`endif

  assign lod_a_in = MAX_BW'(mag_a);
  assign lod_b_in = MAX_BW'(mag_b);

  mitchell_lod #(.W(MAX_BW), .KW(K_BW)) u_lod_a (
    .val(lod_a_in), .k(k_a), .frac(x_a), .zero(zero_a)
  );

  mitchell_lod #(.W(MAX_BW), .KW(K_BW)) u_lod_b (
    .val(lod_b_in), .k(k_b), .frac(x_b), .zero(zero_b)
  );

  // Antilog: mantissa 1.f scaled by 2^(k1+k2+carry), then back down by the fraction width.
  always_comb begin
    s3_exp  = s2_ksum_q + E_BW'(s2_fsum_q[MAX_BW]);
    s3_mant = C_BW'({1'b1, s2_fsum_q[MAX_BW-1:0]});
    if (s2_ctl_q.zero) begin
      s3_mag = {C_BW{1'b0}};
    end else if (s3_exp >= FRAC_SH) begin
      s3_mag = s3_mant << (s3_exp - FRAC_SH);
    end else begin
      s3_mag = s3_mant >> (FRAC_SH - s3_exp);
    end
`ifdef MITCHELL_SIGNED_EN
    s3_res = s2_ctl_q.neg ? ({C_BW{1'b0}} - s3_mag) : s3_mag;
`else
    s3_res = s3_mag;
`endif
  end

  // Pipeline advance: every stage moves together on en, otherwise holds.
  always_comb begin
    if (en) begin
      s1_ctl_d.valid = in_valid;
      s1_ctl_d.zero  = zero_a | zero_b;
`ifdef MITCHELL_SIGNED_EN
      s1_ctl_d.neg   = neg_in;
`endif
      s1_ka_d     = k_a;
      s1_kb_d     = k_b;
      s1_xa_d     = x_a;
      s1_xb_d     = x_b;
      s1_tag_d    = in_tag;
      s2_ctl_d    = s1_ctl_q;
      s2_ksum_d   = E_BW'(s1_ka_q) + E_BW'(s1_kb_q);
      s2_fsum_d   = {1'b0, s1_xa_q} + {1'b0, s1_xb_q};
      s2_tag_d    = s1_tag_q;
      out_valid_d = s2_ctl_q.valid;
      out_c_d     = s2_ctl_q.valid ? s3_res : {C_BW{1'b0}};
      out_tag_d   = s2_ctl_q.valid ? s2_tag_q : {TAG_BW{1'b0}};
    end else begin
      s1_ctl_d    = s1_ctl_q;
      s1_ka_d     = s1_ka_q;
      s1_kb_d     = s1_kb_q;
      s1_xa_d     = s1_xa_q;
      s1_xb_d     = s1_xb_q;
      s1_tag_d    = s1_tag_q;
      s2_ctl_d    = s2_ctl_q;
      s2_ksum_d   = s2_ksum_q;
      s2_fsum_d   = s2_fsum_q;
      s2_tag_d    = s2_tag_q;
      out_valid_d = out_valid_q;
      out_c_d     = out_c_q;
      out_tag_d   = out_tag_q;
    end
  end

  // State registers with synchronous reset that drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_ctl_q    <= '0;
      s1_ka_q     <= {K_BW{1'b0}};
      s1_kb_q     <= {K_BW{1'b0}};
      s1_xa_q     <= {MAX_BW{1'b0}};
      s1_xb_q     <= {MAX_BW{1'b0}};
      s1_tag_q    <= {TAG_BW{1'b0}};
      s2_ctl_q    <= '0;
      s2_ksum_q   <= {E_BW{1'b0}};
      s2_fsum_q   <= {(MAX_BW+1){1'b0}};
      s2_tag_q    <= {TAG_BW{1'b0}};
      out_valid_q <= 1'b0;
      out_c_q     <= {C_BW{1'b0}};
      out_tag_q   <= {TAG_BW{1'b0}};
    end else begin
      s1_ctl_q    <= s1_ctl_d;
      s1_ka_q     <= s1_ka_d;
      s1_kb_q     <= s1_kb_d;
      s1_xa_q     <= s1_xa_d;
      s1_xb_q     <= s1_xb_d;
      s1_tag_q    <= s1_tag_d;
      s2_ctl_q    <= s2_ctl_d;
      s2_ksum_q   <= s2_ksum_d;
      s2_fsum_q   <= s2_fsum_d;
      s2_tag_q    <= s2_tag_d;
      out_valid_q <= out_valid_d;
      out_c_q     <= out_c_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_c     = out_c_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_mitchell_mult_pipe.sv
// Self-checking bench for mitchell_mult_pipe (8x8 configuration): directed table,
// stall/reset sequences and randomized traffic against an integer Mitchell model.
module tb_mitchell_mult_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = 8'd0;
  logic [7:0]  in_b = 8'd0;
  logic [3:0]  in_tag = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_c;
  logic [3:0]  out_tag;

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    logic [15:0] c;
    logic [3:0]  tag;
  } exp_t;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  tag;
    logic [15:0] c;
  } vec_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  mitchell_mult_pipe #(.A_BW(8), .B_BW(8), .TAG_BW(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_tag(out_tag)
  );

  // Mitchell product from integer logs: a = 2^ka + fa, b = 2^kb + fb,
  // S = fa*2^kb + fb*2^ka over D = 2^(ka+kb); no carry -> D+S, carry -> 2S.
  function automatic logic [15:0] ref_mult(input logic [7:0] a, input logic [7:0] b);
    longint ma, mb, d, s, r;
    int ka, kb;
    bit neg;
    ma = longint'(a);
    mb = longint'(b);
    neg = 1'b0;
`ifdef MITCHELL_SIGNED_EN
    if (a[7]) begin ma = 256 - ma; neg = ~neg; end
    if (b[7]) begin mb = 256 - mb; neg = ~neg; end
`endif
    if (ma == 0 || mb == 0) return 16'd0;
    ka = 0;
    while ((longint'(1) << (ka + 1)) <= ma) ka++;
    kb = 0;
    while ((longint'(1) << (kb + 1)) <= mb) kb++;
    d = longint'(1) << (ka + kb);
    s = ((ma - (longint'(1) << ka)) << kb) + ((mb - (longint'(1) << kb)) << ka);
    r = (s < d) ? (d + s) : (2 * s);
    if (neg) r = -r;
    return r[15:0];
  endfunction

  function automatic logic [7:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 8'd0;
      1: return 8'(32'd1 << $urandom_range(0, 7));
      2: return 8'h80;
      3: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Scoreboard: handshake rule every cycle, in-order results on each output transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
    end else if (mon_en) begin
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++;
        $display("FAIL in_ready_rule: got %b expected %b", in_ready, (!out_valid || out_ready));
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got c=0x%0h tag=%0d expected no output", out_c, out_tag);
        end else begin
          e = exp_q.pop_front();
          if (out_c !== e.c || out_tag !== e.tag) begin
            errors++;
            $display("FAIL result: got c=0x%0h tag=%0d expected c=0x%0h tag=%0d",
                     out_c, out_tag, e.c, e.tag);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back('{c: ref_mult(in_a, in_b), tag: in_tag});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    int   base;
    int   idx;
`ifdef MITCHELL_SIGNED_EN
    vecs[0] = '{8'hFD, 8'h03, 4'd1, 16'hFFF8};
    vecs[1] = '{8'h80, 8'h01, 4'd2, 16'hFF80};
    vecs[2] = '{8'h80, 8'h80, 4'd3, 16'h4000};
    vecs[3] = '{8'h05, 8'hF9, 4'd4, 16'hFFE0};
    vecs[4] = '{8'h00, 8'hFB, 4'd5, 16'h0000};
    vecs[5] = '{8'h03, 8'h03, 4'd6, 16'h0008};
    vecs[6] = '{8'hFF, 8'hFF, 4'd7, 16'h0001};
    vecs[7] = '{8'h06, 8'hFA, 4'd8, 16'hFFE0};
`else
    vecs[0] = '{8'd3,   8'd3,   4'd1, 16'd8};
    vecs[1] = '{8'd5,   8'd7,   4'd2, 16'd32};
    vecs[2] = '{8'd8,   8'd16,  4'd3, 16'd128};
    vecs[3] = '{8'd255, 8'd255, 4'd4, 16'd65024};
    vecs[4] = '{8'd0,   8'd200, 4'd5, 16'd0};
    vecs[5] = '{8'd200, 8'd0,   4'd6, 16'd0};
    vecs[6] = '{8'd6,   8'd6,   4'd7, 16'd32};
    vecs[7] = '{8'd3,   8'd5,   4'd8, 16'd14};
`endif

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_c", 32'(out_c), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    mon_en = 1'b1;

    for (int v = 0; v < 8; v++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_a      = vecs[v].a;
      in_b      = vecs[v].b;
      in_tag    = vecs[v].tag;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("lat_cycle1_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check("lat_cycle2_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check("lat_cycle3_valid", 32'(out_valid), 32'd1);
      check("vec_out_c", 32'(out_c), 32'(vecs[v].c));
      check("vec_out_tag", 32'(out_tag), 32'(vecs[v].tag));
    end

    // Back-to-back stream with the consumer stalled for cycles 4..6.
    @(posedge clk); #1;
    base = out_cnt;
    idx  = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 4 && cyc <= 6);
      if (idx < 10) begin
        in_valid = 1'b1;
        in_a     = pick_operand();
        in_b     = pick_operand();
        in_tag   = 4'(idx);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc >= 4 && cyc <= 6) begin
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_in_ready", 32'(in_ready), 32'd0);
      end
      if (in_valid && in_ready) idx++;
    end
    check("stream_out_count", 32'(out_cnt - base), 32'd10);
    check("stream_drained", 32'(exp_q.size()), 32'd0);

    // Reset with three operations in flight and the consumer stalled.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a     = pick_operand();
      in_b     = pick_operand();
      in_tag   = 4'(i + 10);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_c", 32'(out_c), 32'd0);
    check("mid_rst_out_tag", 32'(out_tag), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("no_stale_output", 32'(out_valid), 32'd0);
    end

    // Randomized traffic with random producer and consumer stalls.
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_a      = pick_operand();
      in_b      = pick_operand();
      in_tag    = 4'($urandom);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("random_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
